// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true-LRU ages, valid/dirty state
// and registered one-cycle responses for hit service, write-back and fill.
module dcache_sram_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              valid_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [TAG_W+1:0]  tag_o,
    output logic [LINE_W-1:0] data_o
);

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             found_inv;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] sel_way;
    logic [WAY_W-1:0] old_age;
    logic             new_dirty;
    logic             upd_lru;
    logic             do_write;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age_q[addr_i][w] == WAY_W'(WAYS - 1))
                lru_way = WAY_W'(w);
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[addr_i][w]) begin
                found_inv = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        sel_way   = hit ? hit_way : (found_inv ? inv_way : lru_way);
        old_age   = age_q[addr_i][sel_way];
        new_dirty = hit ? (dirty_q[addr_i][sel_way] | dirty_i) : dirty_i;
        do_write  = enable_i && write_i;
        upd_lru   = enable_i && (hit || write_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
            valid_o <= 1'b0;
            hit_o   <= 1'b0;
            way_o   <= '0;
            tag_o   <= '0;
            data_o  <= '0;
        end else begin
            valid_o <= enable_i;
            if (enable_i) begin
                hit_o <= hit;
                way_o <= sel_way;
                if (write_i) begin
                    tag_o  <= {1'b1, new_dirty, tag_i};
                    data_o <= data_i;
                end else begin
                    tag_o  <= {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way],
                               tag_q[addr_i][sel_way]};
                    data_o <= data_q[addr_i][sel_way];
                end
            end
            if (upd_lru) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == sel_way)
                        age_q[addr_i][w] <= '0;
                    else if (age_q[addr_i][w] < old_age)
                        age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
                end
            end
            if (do_write) begin
                valid_q[addr_i][sel_way] <= 1'b1;
                dirty_q[addr_i][sel_way] <= new_dirty;
                tag_q[addr_i][sel_way]   <= tag_i;
            end
        end
    end

    // Data RAM has no reset; writes are still blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && do_write)
            data_q[addr_i][sel_way] <= data_i;
    end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Randomized and directed bench for dcache_sram_nway against a recency-list cache model.
module tb_dcache_sram_nway;
    localparam int WAYS   = 4;
    localparam int SETS   = 16;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 64;
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              enable_i = 1'b0;
    logic              write_i = 1'b0;
    logic [IDX_W-1:0]  addr_i = '0;
    logic [TAG_W-1:0]  tag_i = '0;
    logic [LINE_W-1:0] data_i = '0;
    logic              dirty_i = 1'b0;
    logic              valid_o;
    logic              hit_o;
    logic [WAY_W-1:0]  way_o;
    logic [TAG_W+1:0]  tag_o;
    logic [LINE_W-1:0] data_o;

    dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i),
        .valid_o(valid_o), .hit_o(hit_o), .way_o(way_o), .tag_o(tag_o), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Model: per-set recency list, position 0 = most recent, last = LRU.
    bit                m_v   [SETS][WAYS];
    bit                m_d   [SETS][WAYS];
    logic [TAG_W-1:0]  m_t   [SETS][WAYS];
    logic [LINE_W-1:0] m_dat [SETS][WAYS];
    bit                m_dk  [SETS][WAYS];
    int                ord   [SETS][WAYS];

    logic              e_valid, e_hit;
    logic [WAY_W-1:0]  e_way;
    logic [TAG_W+1:0]  e_tag;
    logic [LINE_W-1:0] e_data;
    bit                e_dk;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 0; m_d[s][w] = 0; m_t[s][w] = '0; m_dk[s][w] = 0;
                ord[s][w] = w;
            end
        e_valid = 0; e_hit = 0; e_way = '0; e_tag = '0; e_data = '0; e_dk = 1;
    endtask

    task automatic touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endtask

    task automatic model_req(input bit wr, input int a, input logic [TAG_W-1:0] t,
                             input logic [LINE_W-1:0] d, input bit di);
        int hw = -1;
        int sel = -1;
        for (int w = 0; w < WAYS; w++) if (m_v[a][w] && m_t[a][w] == t) hw = w;
        if (hw >= 0) sel = hw;
        else begin
            for (int w = 0; w < WAYS; w++) if (!m_v[a][w] && sel < 0) sel = w;
            if (sel < 0) sel = ord[a][WAYS-1];
        end
        e_valid = 1; e_hit = (hw >= 0); e_way = WAY_W'(sel);
        if (wr) begin
            m_d[a][sel] = (hw >= 0) ? (m_d[a][sel] | di) : di;
            m_v[a][sel] = 1; m_t[a][sel] = t; m_dat[a][sel] = d; m_dk[a][sel] = 1;
        end
        e_tag = {m_v[a][sel], m_d[a][sel], m_t[a][sel]};
        e_data = m_dat[a][sel]; e_dk = m_dk[a][sel];
        if (hw >= 0 || wr) touch(a, sel);
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".valid"}, 128'(valid_o), 128'(e_valid));
        chk({pfx, ".hit"},   128'(hit_o),   128'(e_hit));
        chk({pfx, ".way"},   128'(way_o),   128'(e_way));
        chk({pfx, ".tag"},   128'(tag_o),   128'(e_tag));
        if (e_dk) chk({pfx, ".data"}, 128'(data_o), 128'(e_data));
    endtask

    task automatic do_req(input string pfx, input bit en, input bit wr, input int a,
                          input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d, input bit di);
        @(negedge clk_i);
        enable_i = en; write_i = wr; addr_i = IDX_W'(a); tag_i = t; data_i = d; dirty_i = di;
        if (en) model_req(wr, a, t, d, di);
        else e_valid = 0;
        @(posedge clk_i);
        #1;
        check_outputs(pfx);
    endtask

    localparam logic [LINE_W-1:0] A5 = {(LINE_W/8){8'hA5}};
    logic [LINE_W-1:0] wd;

    initial begin
        model_reset();
        #12;
        chk("reset.valid", 128'(valid_o), 128'(0));
        chk("reset.tag",   128'(tag_o),   128'(0));
        chk("reset.data",  128'(data_o),  128'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;

        do_req("cold", 1, 0, 3, 23'h12, '0, 0);
        chk("cold.hit_const", 128'(hit_o), 128'(0));
        chk("cold.way_const", 128'(way_o), 128'(0));
        do_req("fill_a5", 1, 1, 3, 23'h12, A5, 0);
        do_req("hit_a5", 1, 0, 3, 23'h12, '0, 0);
        chk("hit_a5.data_const", 128'(data_o), 128'(A5));
        chk("hit_a5.tag_const", 128'(tag_o), 128'({2'b10, 23'h12}));

        for (int i = 1; i <= 4; i++) do_req("lru_fill", 1, 1, 5, TAG_W'(i), LINE_W'(i), 0);
        do_req("lru_rd1", 1, 0, 5, 23'd1, '0, 0);
        chk("lru_rd1.way_const", 128'(way_o), 128'(0));
        do_req("lru_rd9", 1, 0, 5, 23'd9, '0, 0);
        chk("lru_rd9.way_const", 128'(way_o), 128'(1));
        chk("lru_rd9.tag_const", 128'(tag_o), 128'({2'b10, 23'd2}));
        do_req("lru_fill9", 1, 1, 5, 23'd9, 64'h99, 0);
        chk("lru_fill9.way_const", 128'(way_o), 128'(1));

        do_req("wb_fill7", 1, 1, 6, 23'd7, 64'h7777, 0);
        wd = 64'hDEAD_BEEF_0BAD_F00D;
        do_req("wb_hit7", 1, 1, 6, 23'd7, wd, 1);
        chk("wb_hit7.tag_const", 128'(tag_o), 128'({2'b11, 23'd7}));
        do_req("b2b_rd7", 1, 0, 6, 23'd7, '0, 0);
        chk("b2b_rd7.data_const", 128'(data_o), 128'(wd));
        chk("b2b_rd7.hit_const", 128'(hit_o), 128'(1));
        for (int i = 0; i < 3; i++) do_req("wb_fill", 1, 1, 6, TAG_W'(20 + i), LINE_W'(i), 0);
        do_req("wb_evict", 1, 0, 6, 23'd30, '0, 0);
        chk("wb_evict.tag_const", 128'(tag_o), 128'({2'b11, 23'd7}));
        chk("wb_evict.data_const", 128'(data_o), 128'(wd));
        do_req("idle", 0, 0, 6, 23'd0, '0, 0);

        // Reset asserted between edges while a fill to set 3 is presented.
        @(negedge clk_i);
        enable_i = 1; write_i = 1; addr_i = 3; tag_i = 23'h55; data_i = A5; dirty_i = 1;
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_mid.valid", 128'(valid_o), 128'(0));
        chk("rst_mid.tag",   128'(tag_o),   128'(0));
        chk("rst_mid.way",   128'(way_o),   128'(0));
        model_reset();
        @(negedge clk_i);
        enable_i = 0;
        rst_n_i = 1'b1;
        do_req("rst_after", 1, 0, 3, 23'h55, '0, 0);
        chk("rst_after.hit_const", 128'(hit_o), 128'(0));
        chk("rst_after.way_const", 128'(way_o), 128'(0));
        do_req("rst_after12", 1, 0, 3, 23'h12, '0, 0);

        for (int n = 0; n < 400; n++) begin
            do_req("rnd", ($urandom_range(0, 99) < 85), $urandom_range(0, 1),
                   $urandom_range(0, 3), TAG_W'($urandom_range(0, 6)),
                   {$urandom, $urandom}, $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/dcache_sram_nway.md
# dcache_sram_nway

Parametrised N-way set-associative data-cache storage array with true-LRU replacement, per-line valid/dirty state and registered responses. It sits between the dcache controller and the core's load/store path, and is the multi-way successor to the current 2-way array. Every request returns hit status, the selected way, and the line/tag the controller needs for:
- hit service;
- dirty-victim write-back;
- fill.

## Interface
- WAYS, 2, associativity; power of two, at least 2
- SETS, 16, number of sets; power of two, at least 2
- TAG_W, 23, stored address-tag bits
- LINE_W, 256, cache line width in bits
- Derived: IDX_W = log2(SETS), WAY_W = log2(WAYS)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_n_i  in  1  reset; asynchronous assert, active-low
- enable_i  in  1  request valid this cycle
- write_i  in  1  1 = write (hit-update or fill), 0 = lookup
- addr_i  in  IDX_W  set index
- tag_i  in  TAG_W  request tag
- data_i  in  LINE_W  write/fill line data
- dirty_i  in  1  dirty value for the written line
- valid_o  out  1  response valid; one pulse per accepted request
- hit_o  out  1  tag matched in a valid way
- way_o  out  WAY_W  way hit, or way chosen as victim on a miss
- tag_o  out  TAG_W+2  {valid, dirty, tag} of the way reported in way_o
- data_o  out  LINE_W  line held in the way reported in way_o

## Operation
- Storage per set and way: valid bit, dirty bit, TAG_W tag, LINE_W data, WAY_W LRU age.
- Hit: valid and tag equal. At most one way can hit, because fills occur only on a miss.
- Victim selection:
  - lowest-index invalid way, if any;
  - otherwise the way with age WAYS-1.
- LRU update on every hit and every fill of way w with old age a:
  - every way in that set whose age is below a increments by 1;
  - way w's age becomes 0;
  - ages stay a permutation of 0..WAYS-1.
- Lookup hit (write_i=0): report the hit way and its line; update LRU; no other state change.
- Lookup miss: report the victim's stored {valid, dirty, tag} and data for write-back. No state change, and no LRU update.
- Write hit:
  - line in the hit way replaced by data_i;
  - dirty becomes old dirty OR dirty_i;
  - valid stays 1;
  - LRU updated;
  - response shows the post-write tag and data.
- Write miss (fill):
  - victim way gets valid=1, dirty=dirty_i, tag=tag_i, data=data_i;
  - LRU updated;
  - response has hit_o=0, the victim way, and the post-write tag and data.
- enable_i=0: no state change; valid_o=0; other outputs hold their last values.

## Timing
- The request is sampled at rising edge k. valid_o, hit_o, way_o, tag_o and data_o are registered and valid after edge k, i.e. one-cycle latency.
- Array and LRU updates also commit at edge k. A request at edge k+1 to the same set sees the updated contents, so back-to-back requests are allowed at one per cycle.
- There is no stall or backpressure; every enable_i cycle is accepted.
- Reset while rst_n_i=0, taking effect immediately:
  - all valid and dirty bits cleared;
  - all tags cleared to 0;
  - age of way i in every set set to i, making way WAYS-1 the LRU;
  - outputs set to valid_o=0, hit_o=0, way_o=0, tag_o=0, data_o=0;
  - data RAM contents are not reset.
- Reset mid-request: the in-flight response is dropped and no partial write commits.
- The first request after deassertion is accepted on the first rising edge with rst_n_i=1.

## Test plan
- Cold lookup, WAYS=4: after reset, read set 3, tag 0x12 -> valid_o=1 next cycle, hit_o=0, way_o=0, tag_o={0,0,0}.
- Fill then hit: write set 3, tag 0x12, data 0xA5..A5, dirty_i=0; then read the same address -> hit_o=1, way_o=0, data_o=0xA5..A5, tag_o={1,0,0x12}.
- LRU eviction, WAYS=4:
  - stimulus: fill tags 1,2,3,4 into set 5; read tag 1; then read tag 9;
  - required: the read of tag 1 hits way 0; the read of tag 9 misses with way_o=1 (tag 2, the LRU);
  - follow-up: fill tag 9 -> lands in way 1.
- Dirty write-back path:
  - fill tag 7 clean; write-hit tag 7 with dirty_i=1 -> tag_o dirty=1;
  - force eviction of that way -> a lookup miss reports tag_o={1,1,7} and the written data.
- Back-to-back: a write hit at edge k and a read of the same line at edge k+1 -> the read returns the new data with hit_o=1.
- Async reset mid-stream: drop rst_n_i between edges during a fill -> outputs clear immediately; a later lookup of that address gives hit_o=0; the victim is way 0.
